rojobot_model: RTL and testbench
================================

ROJOBOT_MODEL -- requirements
Module: rojobot_model

Interface
REQ-001 Parameter UPD_PERIOD, default 5000000, clocks between system-register updates (legal range 2..2^24).
REQ-002 Parameter INIT_X, default 64, LocX reset value (0..127).
REQ-003 Parameter INIT_Y, default 64, LocY reset value (0..127).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 MotCtl_in  input  8  motor control: [7] left dir (1=fwd), [6:4] left speed, [3] right dir, [2:0] right speed.
REQ-007 LocX_reg  output  8  X coordinate, 0..127, bit 7 always 0.
REQ-008 LocY_reg  output  8  Y coordinate, 0..127, bit 7 always 0; 0 = north edge.
REQ-009 Sensors_reg  output  8  {3'b000, bump, north, south, west, east}.
REQ-010 BotInfo_reg  output  8  {1'b0, heading[2:0], movement[3:0]}.
REQ-011 LMDist_reg  output  8  left motor activity count.
REQ-012 RMDist_reg  output  8  right motor activity count.
REQ-013 upd_sysregs  output  1  one-cycle pulse: registers just updated.

Function
REQ-014 Free-running tick counter SHALL count 0..UPD_PERIOD-1 and wrap to 0; tick = counter at UPD_PERIOD-1.
REQ-015 On the tick edge MotCtl_in SHALL be sampled and all output registers updated together; no output changes on any other edge except upd_sysregs deassertion.
REQ-016 upd_sysregs SHALL be 1 for exactly the cycle after each tick edge, 0 otherwise; period exactly UPD_PERIOD cycles.
REQ-017 Motor "active" = speed field nonzero; direction bit ignored when speed is 0.
REQ-018 Movement decode (L,R = fwd/rev/off): fwd,fwd->1 FWD; rev,rev->2 REV; off,off->0 STOP; fwd,rev or fwd,off or off,rev->4 SPIN_RIGHT; rev,fwd or off,fwd or rev,off->3 SPIN_LEFT; codes 5..15 never produced.
REQ-019 Speed magnitudes SHALL NOT affect motion; one step per tick.
REQ-020 Heading 0..7 = N,NE,E,SE,S,SW,W,NW; SPIN_RIGHT heading+1 mod 8, SPIN_LEFT heading-1 mod 8 (0->7), position unchanged.
REQ-021 FWD moves one unit along heading: N y-1, NE x+1 y-1, E x+1, SE x+1 y+1, S y+1, SW x-1 y+1, W x-1, NW x-1 y-1; REV moves the opposite vector; heading unchanged.
REQ-022 If either candidate coordinate leaves 0..127, position SHALL remain unchanged entirely (no partial diagonal move) and bump=1; otherwise bump=0; bump is 0 for STOP/SPIN.
REQ-023 Wall bits SHALL reflect the post-update position: north=(y==0), south=(y==127), west=(x==0), east=(x==127).
REQ-024 BotInfo_reg SHALL carry post-update heading and the decoded movement code of the sampled MotCtl_in.
REQ-025 LMDist_reg/RMDist_reg SHALL increment by 1 on each tick where the respective motor is active, regardless of direction or blocking, wrapping 255->0.
REQ-026 MotCtl_in changes between ticks SHALL have no effect; only the tick-cycle value matters.

Reset
REQ-027 reset low SHALL immediately force: counter 0, LocX=INIT_X, LocY=INIT_Y, heading 0, BotInfo_reg 0x00, LMDist/RMDist 0, upd_sysregs 0, Sensors_reg to wall bits of (INIT_X,INIT_Y) with bump 0 (0x00 for defaults).
REQ-028 Reset asserted mid-period or coincident with a tick SHALL discard that update; first post-release tick occurs UPD_PERIOD edges after release.

Verification (UPD_PERIOD=4, defaults otherwise)
REQ-029 Reset release, MotCtl=0x00, 12 cycles -> upd_sysregs pulses every 4 cycles, Loc (64,64), BotInfo 0x00, Dist 0.
REQ-030 MotCtl=0x99 for 3 ticks -> LocY 63,62,61, LocX 64, BotInfo 0x01, LMDist=RMDist=3.
REQ-031 MotCtl=0x91 (L fwd, R rev) 9 ticks -> heading 1..7,0,1, BotInfo last 0x14, Loc unchanged; MotCtl=0x19 from heading 0 -> heading 7, BotInfo 0x73.
REQ-032 INIT_Y=1, MotCtl=0x99: tick1 LocY=0 Sensors 0x08; tick2 LocY=0 Sensors 0x18; then MotCtl=0x11 -> LocY=1 Sensors 0x00, BotInfo 0x02.
REQ-033 INIT_X=127, heading driven to 1 (NE), INIT_Y=64, FWD -> LocX 127, LocY 64 unchanged, bump=1, east=1 (Sensors 0x11).
REQ-034 Reset pulsed low 2 cycles before a tick -> no upd_sysregs that period, outputs at reset values, next pulse 4 cycles after release; LMDist wrap 255->0 after 256 active ticks.

Source files
------------

// File: rtl/rojobot_model.sv
// Behavioural Rojobot: a robot on a 128x128 grid that takes one motion step per
// update period. The motor command is sampled and all status registers change together at each update.
module rojobot_model #(
    parameter int UPD_PERIOD = 5000000,
    parameter int INIT_X     = 64,
    parameter int INIT_Y     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] MotCtl_in,
    output logic [7:0] LocX_reg,
    output logic [7:0] LocY_reg,
    output logic [7:0] Sensors_reg,
    output logic [7:0] BotInfo_reg,
    output logic [7:0] LMDist_reg,
    output logic [7:0] RMDist_reg,
    output logic       upd_sysregs
);
    localparam int CW = (UPD_PERIOD > 2) ? $clog2(UPD_PERIOD) : 1;
    localparam logic [6:0] IX = 7'(INIT_X);
    localparam logic [6:0] IY = 7'(INIT_Y);
    localparam logic [7:0] RST_SENS = {4'b0000, IY == 7'd0, IY == 7'd127, IX == 7'd0, IX == 7'd127};

    typedef enum logic [3:0] {
        MV_STOP  = 4'd0,
        MV_FWD   = 4'd1,
        MV_REV   = 4'd2,
        MV_SPINL = 4'd3,
        MV_SPINR = 4'd4
    } move_t;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [2:0]    hdg, hdg_nxt;
    logic          l_act, r_act, l_fwd, l_rev, r_fwd, r_rev;
    move_t         mv;
    logic [1:0]    sx, sy;
    logic [8:0]    cx, cy;
    logic          moving, blocked;
    logic [6:0]    x_nxt, y_nxt;

    assign tick  = (cnt == CW'(UPD_PERIOD - 1));

    // A motor with zero speed is off whatever its direction bit says.
    assign l_act = |MotCtl_in[6:4];
    assign r_act = |MotCtl_in[2:0];
    assign l_fwd = l_act & MotCtl_in[7];
    assign l_rev = l_act & ~MotCtl_in[7];
    assign r_fwd = r_act & MotCtl_in[3];
    assign r_rev = r_act & ~MotCtl_in[3];

    always_comb begin
        mv = MV_STOP;
        if (l_fwd && r_fwd)       mv = MV_FWD;
        else if (l_rev && r_rev)  mv = MV_REV;
        else if (!l_act && !r_act) mv = MV_STOP;
        else if (l_fwd || r_rev)  mv = MV_SPINR;
        else                      mv = MV_SPINL;
    end

    // Unit step for the current heading, two's complement in 2 bits (y grows southward).
    always_comb begin
        sx = 2'b00;
        sy = 2'b00;
        case (hdg)
            3'd0: begin sx = 2'b00; sy = 2'b11; end
            3'd1: begin sx = 2'b01; sy = 2'b11; end
            3'd2: begin sx = 2'b01; sy = 2'b00; end
            3'd3: begin sx = 2'b01; sy = 2'b01; end
            3'd4: begin sx = 2'b00; sy = 2'b01; end
            3'd5: begin sx = 2'b11; sy = 2'b01; end
            3'd6: begin sx = 2'b11; sy = 2'b00; end
            default: begin sx = 2'b11; sy = 2'b11; end
        endcase
        if (mv == MV_REV) begin
            sx = 2'(~sx + 2'd1);
            sy = 2'(~sy + 2'd1);
        end
    end

    // Off-grid candidates (-1 or 128) show up as nonzero upper bits in 9-bit arithmetic.
    assign cx      = {2'b00, LocX_reg[6:0]} + {{7{sx[1]}}, sx};
    assign cy      = {2'b00, LocY_reg[6:0]} + {{7{sy[1]}}, sy};
    assign moving  = (mv == MV_FWD) || (mv == MV_REV);
    assign blocked = moving && ((cx[8:7] != 2'b00) || (cy[8:7] != 2'b00));
    assign x_nxt   = (moving && !blocked) ? cx[6:0] : LocX_reg[6:0];
    assign y_nxt   = (moving && !blocked) ? cy[6:0] : LocY_reg[6:0];

    always_comb begin
        hdg_nxt = hdg;
        if (mv == MV_SPINR)      hdg_nxt = hdg + 3'd1;
        else if (mv == MV_SPINL) hdg_nxt = hdg - 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            hdg         <= 3'd0;
            LocX_reg    <= {1'b0, IX};
            LocY_reg    <= {1'b0, IY};
            Sensors_reg <= RST_SENS;
            BotInfo_reg <= 8'h00;
            LMDist_reg  <= 8'h00;
            RMDist_reg  <= 8'h00;
            upd_sysregs <= 1'b0;
        end else begin
            upd_sysregs <= tick;
            cnt         <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                hdg         <= hdg_nxt;
                LocX_reg    <= {1'b0, x_nxt};
                LocY_reg    <= {1'b0, y_nxt};
                Sensors_reg <= {3'b000, blocked, y_nxt == 7'd0, y_nxt == 7'd127,
                                x_nxt == 7'd0, x_nxt == 7'd127};
                BotInfo_reg <= {1'b0, hdg_nxt, mv};
                LMDist_reg  <= LMDist_reg + {7'd0, l_act};
                RMDist_reg  <= RMDist_reg + {7'd0, r_act};
            end
        end
    end
endmodule

// File: tb/tb_rojobot_model.sv
// Scoreboard bench for rojobot_model: a grid-walk reference model predicts each update,
// and a monitor checks every update pulse and that outputs hold steady between pulses.
module tb_rojobot_model;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] MotCtl_in;
    logic [7:0] LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, LMDist_reg, RMDist_reg;
    logic       upd_sysregs;

    rojobot_model #(.UPD_PERIOD(P), .INIT_X(64), .INIT_Y(64)) dut (
        .clk(clk), .reset(reset), .MotCtl_in(MotCtl_in),
        .LocX_reg(LocX_reg), .LocY_reg(LocY_reg), .Sensors_reg(Sensors_reg),
        .BotInfo_reg(BotInfo_reg), .LMDist_reg(LMDist_reg), .RMDist_reg(RMDist_reg),
        .upd_sysregs(upd_sysregs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x, y, sens, info, ld, rd;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;
    int   mx, my, mh, mld, mrd;
    int   DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int   DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic exp_t pack_state(bit bump, int mv);
        exp_t e;
        e.x    = 8'(mx);
        e.y    = 8'(my);
        e.sens = {3'b000, bump, my == 0, my == 127, mx == 0, mx == 127};
        e.info = {1'b0, 3'(mh), 4'(mv)};
        e.ld   = 8'(mld);
        e.rd   = 8'(mrd);
        return e;
    endfunction

    task automatic model_reset();
        mx = 64; my = 64; mh = 0; mld = 0; mrd = 0;
    endtask

    // Reference: motors as -1/0/+1, then grid arithmetic on integers.
    task automatic model_tick(input logic [7:0] m, output exp_t e);
        int  l, r, mv, s, nx, ny;
        bit  bump;
        l = (m[6:4] == 3'd0) ? 0 : (m[7] ? 1 : -1);
        r = (m[2:0] == 3'd0) ? 0 : (m[3] ? 1 : -1);
        if (l == r) mv = (l == 1) ? 1 : ((l == -1) ? 2 : 0);
        else        mv = (l > r) ? 4 : 3;
        bump = 0;
        if (mv == 4)      mh = (mh + 1) % 8;
        else if (mv == 3) mh = (mh + 7) % 8;
        else if (mv == 1 || mv == 2) begin
            s  = (mv == 1) ? 1 : -1;
            nx = mx + s * DX[mh];
            ny = my + s * DY[mh];
            if (nx < 0 || nx > 127 || ny < 0 || ny > 127) bump = 1;
            else begin mx = nx; my = ny; end
        end
        if (l != 0) mld = (mld + 1) % 256;
        if (r != 0) mrd = (mrd + 1) % 256;
        e = pack_state(bump, mv);
    endtask

    // Junk on the non-sampling edges; the real command is held only across the tick edge.
    task automatic do_tick(input logic [7:0] m);
        exp_t e;
        repeat (P - 1) begin
            MotCtl_in = 8'($urandom);
            @(negedge clk);
        end
        MotCtl_in = m;
        model_tick(m, e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset(string name);
        exp_t r;
        model_reset();
        r = pack_state(0, 0);
        chk(name, {15'd0, upd_sysregs, LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, LMDist_reg, RMDist_reg},
            {15'd0, 1'b0, r});
    endtask

    task automatic reset_mid(input int k);
        repeat (k) begin
            MotCtl_in = 8'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        check_reset($sformatf("reset_after_%0d", k));
        reset = 1'b1;
    endtask

    int cyc = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            last = {8'd64, 8'd64, 8'h00, 8'h00, 8'h00, 8'h00};
            cyc  = 0;
        end else begin
            cyc++;
            if (upd_sysregs) begin
                chk("pulse_period", 64'(cyc), 64'(P));
                cyc = 0;
                if (q.size() == 0) begin
                    chk("unexpected_pulse", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("LocX", 64'(LocX_reg), 64'(e.x));
                    chk("LocY", 64'(LocY_reg), 64'(e.y));
                    chk("Sensors", 64'(Sensors_reg), 64'(e.sens));
                    chk("BotInfo", 64'(BotInfo_reg), 64'(e.info));
                    chk("LMDist", 64'(LMDist_reg), 64'(e.ld));
                    chk("RMDist", 64'(RMDist_reg), 64'(e.rd));
                    last = e;
                end
            end else begin
                chk("hold_between_ticks",
                    64'({LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, LMDist_reg, RMDist_reg}),
                    64'(last));
                if (cyc > 2 * P) begin
                    chk("pulse_timeout", 64'(cyc), 64'(P));
                    cyc = 0;
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        MotCtl_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        reset = 1'b1;

        repeat (3) do_tick(8'h00);
        repeat (3) do_tick(8'h99);
        repeat (9) do_tick(8'h91);
        repeat (2) do_tick(8'h19);
        do_tick(8'h91);
        repeat (70) do_tick(8'h99);     // run into the north wall and keep bumping
        repeat (2) do_tick(8'h91);
        repeat (70) do_tick(8'hFF);     // full speed east into the NE corner
        do_tick(8'h19);
        do_tick(8'hDB);
        do_tick(8'h11);
        do_tick(8'h08);
        do_tick(8'h80);

        reset_mid(2);
        do_tick(8'h99);
        reset_mid(3);
        do_tick(8'h11);

        repeat (400) do_tick(8'($urandom));

        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
